// File: rtl/tdm_comms_pkg.sv
// tdm_comms_pkg: shared packet layout, field offsets and helpers for the TDM comms engine.
// Rev 1.0
`default_nettype none

package tdm_comms_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NODE_W = 7;
  localparam int DEF_CH     = 2;

  function automatic int ch_width(input int ch);
    return (ch <= 1) ? 1 : $clog2(ch);
  endfunction

  localparam int DEF_CH_W  = ch_width(DEF_CH);

  // Field offsets for the default layout {valid, dest, src, ch, data}
  localparam int DATA_LSB  = 0;
  localparam int CH_LSB    = DATA_LSB + DEF_DATA_W;
  localparam int SRC_LSB   = CH_LSB + DEF_CH_W;
  localparam int DEST_LSB  = SRC_LSB + DEF_NODE_W;
  localparam int VALID_BIT = DEST_LSB + DEF_NODE_W;

  localparam logic [DEF_NODE_W-1:0] BROADCAST_ID = {DEF_NODE_W{1'b1}};

  typedef struct packed {
    logic                  valid;
    logic [DEF_NODE_W-1:0] dest;
    logic [DEF_NODE_W-1:0] src;
    logic [DEF_CH_W-1:0]   ch;
    logic [DEF_DATA_W-1:0] data;
  } packet_t;

endpackage

`default_nettype wire

// File: rtl/tdm_comms_engine_if.sv
// tdm_comms_engine_if: GPP and data-plane bus signals of the TDM comms engine.
// Rev 1.0
`default_nettype none

interface tdm_comms_engine_if
  import tdm_comms_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NODE_W = 7,
  parameter int CH     = 2
);
  localparam int CH_W  = ch_width(CH);
  localparam int PKT_W = 1 + 2 * NODE_W + CH_W + DATA_W;

  logic [NODE_W-1:0]    node_id;
  logic [NODE_W-1:0]    max_node;
  logic [PKT_W-1:0]     rx_packet;
  logic [PKT_W-1:0]     tx_packet;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [NODE_W-1:0]    tx_dest;
  logic [CH_W-1:0]      tx_ch;
  logic [DATA_W-1:0]    tx_data;
  logic [CH-1:0]        rx_pop;
  logic [CH-1:0]        rx_empty;
  logic [CH*DATA_W-1:0] rx_data;
  logic [CH*NODE_W-1:0] rx_src;
  logic [CH-1:0]        rx_overflow;
  logic [NODE_W-1:0]    slot;

  modport master (
    output node_id, max_node, rx_packet, tx_valid, tx_dest, tx_ch, tx_data, rx_pop,
    input  tx_packet, tx_ready, rx_empty, rx_data, rx_src, rx_overflow, slot
  );

  modport slave (
    input  node_id, max_node, rx_packet, tx_valid, tx_dest, tx_ch, tx_data, rx_pop,
    output tx_packet, tx_ready, rx_empty, rx_data, rx_src, rx_overflow, slot
  );

endinterface

`default_nettype wire

// File: rtl/tdm_comms_engine_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; push into a full FIFO succeeds only with a same-cycle pop.
// Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop on an empty FIFO is dropped, so push+pop on empty leaves one entry
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/tdm_comms_engine.sv
// tdm_comms_engine: slot-scheduled TX queue and destination-filtered per-channel RX queues.
// Rev 1.0. Optional macro TDM_BROADCAST_EN makes dest all-ones a broadcast address.
`default_nettype none

module tdm_comms_engine
  import tdm_comms_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NODE_W   = 7,
  parameter int CH       = 2,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  tdm_comms_engine_if.slave bus
);

  localparam int CH_W  = ch_width(CH);
  localparam int PKT_W = 1 + 2 * NODE_W + CH_W + DATA_W;
  localparam int TX_W  = NODE_W + CH_W + DATA_W;
  localparam int RX_W  = NODE_W + DATA_W;

  logic [NODE_W-1:0] slot_q;
  logic [PKT_W-1:0]  tx_pkt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else if ((bus.max_node <= NODE_W'(1)) || (slot_q >= bus.max_node - NODE_W'(1))) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  assign bus.slot = slot_q;

  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [TX_W-1:0]   tx_head;
  logic [NODE_W-1:0] tx_head_dest;
  logic [CH_W-1:0]   tx_head_ch;
  logic [DATA_W-1:0] tx_head_data;

  assign bus.tx_ready = !tx_full;
  assign tx_push      = bus.tx_valid && !tx_full;
  assign tx_pop       = (slot_q == bus.node_id) && !tx_empty;
  assign {tx_head_dest, tx_head_ch, tx_head_data} = tx_head;

  sync_fifo #(
    .WIDTH (TX_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   ({bus.tx_dest, bus.tx_ch, bus.tx_data}),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pkt_q <= '0;
    end else if (tx_pop) begin
      tx_pkt_q <= {1'b1, tx_head_dest, bus.node_id, tx_head_ch, tx_head_data};
    end else begin
      tx_pkt_q <= '0;
    end
  end

  assign bus.tx_packet = tx_pkt_q;

  logic              rx_valid;
  logic [NODE_W-1:0] rx_dest;
  logic [NODE_W-1:0] rx_src_id;
  logic [CH_W-1:0]   rx_ch;
  logic [DATA_W-1:0] rx_payload;
  logic              dest_hit;
  logic              accept;

  assign {rx_valid, rx_dest, rx_src_id, rx_ch, rx_payload} = bus.rx_packet;

`ifdef TDM_BROADCAST_EN
  assign dest_hit = (rx_dest == bus.node_id) || (rx_dest == {NODE_W{1'b1}});
`else
  assign dest_hit = (rx_dest == bus.node_id);
`endif

  assign accept = rx_valid && dest_hit && (rx_src_id != bus.node_id);

  // Channels at or above CH match no FIFO and are silently discarded
  for (genvar c = 0; c < CH; c++) begin : g_rx
    logic            push;
    logic            full;
    logic            empty;
    logic            ovf_q;
    logic [RX_W-1:0] head;

    assign push = accept && (rx_ch == CH_W'(c));

    sync_fifo #(
      .WIDTH (RX_W),
      .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (bus.rx_pop[c]),
      .din   ({rx_src_id, rx_payload}),
      .dout  (head),
      .full  (full),
      .empty (empty)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        ovf_q <= 1'b0;
      end else if (push && full && !bus.rx_pop[c]) begin
        ovf_q <= 1'b1;
      end
    end

    assign bus.rx_empty[c]                   = empty;
    assign bus.rx_overflow[c]                = ovf_q;
    assign bus.rx_src[c*NODE_W +: NODE_W]    = head[DATA_W +: NODE_W];
    assign bus.rx_data[c*DATA_W +: DATA_W]   = head[DATA_W-1:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_tdm_comms_engine.sv
// tb_tdm_comms_engine: directed, table-driven checks of the TDM comms engine.
`default_nettype none

module tb_tdm_comms_engine;
  import tdm_comms_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_comms_engine_if #(.DATA_W(16), .NODE_W(7), .CH(2)) bus ();

  tdm_comms_engine #(
    .DATA_W   (16),
    .NODE_W   (7),
    .CH       (2),
    .TX_DEPTH (4),
    .RX_DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic v, input logic [6:0] d, input logic [6:0] s,
                                     input logic c, input logic [15:0] x);
    packet_t p;
    p.valid = v;
    p.dest  = d;
    p.src   = s;
    p.ch    = c;
    p.data  = x;
    return p;
  endfunction

  typedef struct {
    logic [31:0] pkt;
    logic [1:0]  pop;
    logic [1:0]  empty;
    logic [15:0] d0;
    logic [6:0]  s0;
    logic [15:0] d1;
    logic [6:0]  s1;
  } rxv_t;

  rxv_t vecs[11];

  initial begin
    int n;
    bit found;
    logic [31:0] exp_pkt;
    logic [15:0] exp_head;

    rst          = 1'b1;
    bus.node_id  = 7'd3;
    bus.max_node = 7'd4;
    bus.rx_packet = '0;
    bus.tx_valid = 1'b0;
    bus.tx_dest  = '0;
    bus.tx_ch    = '0;
    bus.tx_data  = '0;
    bus.rx_pop   = '0;

    // Reset state
    tick;
    tick;
    check("reset_tx_packet", bus.tx_packet, 0);
    check("reset_slot", bus.slot, 0);
    check("reset_rx_empty", bus.rx_empty, 2'b11);
    check("reset_tx_ready", bus.tx_ready, 1);
    check("reset_overflow", bus.rx_overflow, 0);
    check("reset_rx_data", bus.rx_data, 0);
    rst = 1'b0;

    // TDM send: push at slot 0, appears in the cycle after slot 3
    check("send_slot_start", bus.slot, 0);
    bus.tx_valid = 1'b1;
    bus.tx_dest  = 7'd5;
    bus.tx_ch    = 1'b1;
    bus.tx_data  = 16'hBEEF;
    tick;
    bus.tx_valid = 1'b0;
    check("send_idle_s1", bus.tx_packet, 0);
    tick;
    check("send_idle_s2", bus.tx_packet, 0);
    tick;
    check("send_idle_s3", bus.slot, 3);
    check("send_idle_s3_pkt", bus.tx_packet, 0);
    tick;
    check("send_pkt", bus.tx_packet, 32'h8507BEEF);
    tick;
    check("send_after", bus.tx_packet, 0);

    // TX full: starve the node of its slot, overfill, then drain in order
    bus.max_node = 7'd2;
    tick;
    for (int i = 0; i < 5; i++) begin
      bus.tx_valid = 1'b1;
      bus.tx_dest  = 7'd8;
      bus.tx_ch    = 1'(i % 2);
      bus.tx_data  = 16'hD000 + 16'(i);
      check($sformatf("txfull_ready%0d", i), bus.tx_ready, (i < 4) ? 1 : 0);
      tick;
    end
    bus.tx_valid = 1'b0;
    check("txfull_ready_held", bus.tx_ready, 0);
    bus.max_node = 7'd4;
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick;
      if (bus.tx_packet != 0) begin
        exp_pkt = mk(1'b1, 7'd8, 7'd3, 1'(n % 2), 16'hD000 + 16'(n));
        check($sformatf("txfull_drain%0d", n), bus.tx_packet, exp_pkt);
        check($sformatf("txfull_slot%0d", n), bus.slot, 0);
        n++;
      end
    end
    check("txfull_count", n, 4);
    check("txfull_ready_back", bus.tx_ready, 1);

    // RX filter / FIFO table (node 3)
    vecs[0]  = '{mk(1, 3, 2, 0, 16'h1234), 2'b00, 2'b10, 16'h1234, 7'd2, 16'h0, 7'd0};
    vecs[1]  = '{mk(1, 4, 2, 0, 16'h5555), 2'b00, 2'b10, 16'h1234, 7'd2, 16'h0, 7'd0};
    vecs[2]  = '{mk(1, 3, 3, 0, 16'h6666), 2'b00, 2'b10, 16'h1234, 7'd2, 16'h0, 7'd0};
    vecs[3]  = '{mk(0, 3, 2, 0, 16'h7777), 2'b00, 2'b10, 16'h1234, 7'd2, 16'h0, 7'd0};
    vecs[4]  = '{mk(1, 3, 5, 1, 16'hAAAA), 2'b00, 2'b00, 16'h1234, 7'd2, 16'hAAAA, 7'd5};
    vecs[5]  = '{mk(1, 3, 6, 0, 16'h1111), 2'b01, 2'b00, 16'h1111, 7'd6, 16'hAAAA, 7'd5};
    vecs[6]  = '{mk(1, 7'h7F, 2, 0, 16'h2222), 2'b10, 2'b10, 16'h1111, 7'd6, 16'h0, 7'd0};
`ifdef TDM_BROADCAST_EN
    vecs[7]  = '{32'h0, 2'b01, 2'b10, 16'h2222, 7'd2, 16'h0, 7'd0};
`else
    vecs[7]  = '{32'h0, 2'b01, 2'b11, 16'h0, 7'd0, 16'h0, 7'd0};
`endif
    vecs[8]  = '{32'h0, 2'b11, 2'b11, 16'h0, 7'd0, 16'h0, 7'd0};
    vecs[9]  = '{mk(1, 3, 4, 1, 16'h3333), 2'b10, 2'b01, 16'h0, 7'd0, 16'h3333, 7'd4};
    vecs[10] = '{32'h0, 2'b10, 2'b11, 16'h0, 7'd0, 16'h0, 7'd0};

    for (int i = 0; i < 11; i++) begin
      bus.rx_packet = vecs[i].pkt;
      bus.rx_pop    = vecs[i].pop;
      tick;
      bus.rx_packet = '0;
      bus.rx_pop    = '0;
      check($sformatf("rxv%0d_empty", i), bus.rx_empty, vecs[i].empty);
      check($sformatf("rxv%0d_d0", i), bus.rx_data[15:0], vecs[i].d0);
      check($sformatf("rxv%0d_s0", i), bus.rx_src[6:0], vecs[i].s0);
      check($sformatf("rxv%0d_d1", i), bus.rx_data[31:16], vecs[i].d1);
      check($sformatf("rxv%0d_s1", i), bus.rx_src[13:7], vecs[i].s1);
    end

    // Overflow on channel 1, then push+pop while full
    for (int i = 0; i < 9; i++) begin
      bus.rx_packet = mk(1, 3, 1, 1, 16'h0100 + 16'(i));
      tick;
      bus.rx_packet = '0;
      check($sformatf("ovf_flag%0d", i), bus.rx_overflow, (i == 8) ? 2'b10 : 2'b00);
    end
    check("ovf_head", bus.rx_data[31:16], 16'h0100);
    bus.rx_packet = mk(1, 3, 1, 1, 16'h0200);
    bus.rx_pop    = 2'b10;
    tick;
    bus.rx_packet = '0;
    bus.rx_pop    = '0;
    check("ovf_pushpop_flag", bus.rx_overflow, 2'b10);
    for (int j = 0; j < 8; j++) begin
      exp_head = (j < 7) ? 16'h0101 + 16'(j) : 16'h0200;
      check($sformatf("ovf_drain%0d", j), bus.rx_data[31:16], exp_head);
      check($sformatf("ovf_nonempty%0d", j), bus.rx_empty[1], 0);
      bus.rx_pop = 2'b10;
      tick;
      bus.rx_pop = '0;
    end
    check("ovf_drained", bus.rx_empty, 2'b11);

    // Slot wrap: single slot, node 0 sends back-to-back
    rst          = 1'b1;
    bus.node_id  = 7'd0;
    bus.max_node = 7'd1;
    tick;
    tick;
    rst = 1'b0;
    check("wrap_ovf_cleared", bus.rx_overflow, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("wrap_slot_hold%0d", i), bus.slot, 0);
    end
    bus.tx_valid = 1'b1;
    bus.tx_dest  = 7'd9;
    bus.tx_ch    = 1'b0;
    bus.tx_data  = 16'hC000;
    tick;
    bus.tx_data  = 16'hC001;
    tick;
    check("b2b_0", bus.tx_packet, mk(1, 9, 0, 0, 16'hC000));
    bus.tx_data  = 16'hC002;
    tick;
    check("b2b_1", bus.tx_packet, mk(1, 9, 0, 0, 16'hC001));
    bus.tx_valid = 1'b0;
    tick;
    check("b2b_2", bus.tx_packet, mk(1, 9, 0, 0, 16'hC002));
    tick;
    check("b2b_idle", bus.tx_packet, 0);

    // Lower max_node from 6 to 2 while slot is 5
    bus.max_node = 7'd6;
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      tick;
      if (bus.slot == 7'd5) found = 1'b1;
    end
    check("shrink_reach5", found, 1);
    bus.max_node = 7'd2;
    tick;
    check("shrink_slot0", bus.slot, 0);
    tick;
    check("shrink_slot1", bus.slot, 1);
    tick;
    check("shrink_slot_wrap", bus.slot, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
